seq_detect_ctrl: RTL and testbench

//  Feeds the serial-input 11011 Mealy sequence detector from a parallel word stream.

---
 rtl/seq_detect_ctrl.sv | 108 ++++++++++
 tb/tb_seq_detect_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Parallel-to-serial front end for the 11011 Mealy detector: accepts words over
// valid/ready, shifts them out MSB-first and keeps per-frame match statistics.
module seq_detect_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [CNT_W-1:0]  threshold,
    output logic              det_bit,
    output logic              det_en,
    output logic              det_clr,
    input  logic              det_match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              thr_hit,
    output logic              frame_done,
    output logic              busy
);

    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  shreg;
    logic [BCW-1:0]     bit_cnt;
    logic               last_q;
    logic               frame_open;
    logic [CNT_W-1:0]   thr_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        det_en     = 1'b0;
        det_bit    = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                det_en  = 1'b1;
                det_bit = shreg[DATA_W-1];
                busy    = 1'b1;
                if (bit_cnt == '0) state_nxt = last_q ? DONE : IDLE;
            end
            DONE: begin
                frame_done = 1'b1;
                busy       = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept  = s_valid && s_ready;
    // Only the first word of a frame clears the detector; later words continue its history.
    assign det_clr = accept && !frame_open;
    assign cnt_inc = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            last_q     <= 1'b0;
            frame_open <= 1'b0;
            thr_q      <= '0;
            match_cnt  <= '0;
            thr_hit    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                shreg   <= s_data;
                last_q  <= s_last;
                bit_cnt <= BCW'(DATA_W - 1);
                if (!frame_open) begin
                    thr_q     <= threshold;
                    match_cnt <= '0;
                    thr_hit   <= 1'b0;
                end
            end else if (state == SHIFT) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt - BCW'(1);
                if (det_match) begin
                    match_cnt <= cnt_inc;
                    if (thr_q != '0 && cnt_inc >= thr_q) thr_hit <= 1'b1;
                end
                if (bit_cnt == '0 && !last_q) frame_open <= 1'b1;
            end else if (state == DONE) begin
                frame_open <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: per-cycle vector table on an 8-bit instance with a
// behavioural 11011 detector, plus a CNT_W=3 instance for counter saturation.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid, s_last, s_ready;
    logic [7:0] s_data, threshold, match_cnt;
    logic       det_bit, det_en, det_clr, det_match, thr_hit, frame_done, busy;

    logic       v2, l2, r2, b2, e2, c2, th2, fd2, bz2;
    logic [7:0] d2;
    logic [2:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .threshold(threshold), .det_bit(det_bit), .det_en(det_en),
        .det_clr(det_clr), .det_match(det_match), .match_cnt(match_cnt),
        .thr_hit(thr_hit), .frame_done(frame_done), .busy(busy)
    );

    // Stub detector that matches on every enabled bit, to drive the counter into saturation.
    seq_detect_ctrl #(.DATA_W(8), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .s_valid(v2), .s_ready(r2), .s_data(d2),
        .s_last(l2), .threshold(3'd7), .det_bit(b2), .det_en(e2),
        .det_clr(c2), .det_match(e2), .match_cnt(cnt2),
        .thr_hit(th2), .frame_done(fd2), .busy(bz2)
    );

    // Overlapping 11011 detector; state = length of matched prefix.
    logic [2:0] dst = 3'd0;

    function automatic logic [2:0] dnext(input logic [2:0] s, input logic b);
        case (s)
            3'd0:    return b ? 3'd1 : 3'd0;
            3'd1:    return b ? 3'd2 : 3'd0;
            3'd2:    return b ? 3'd2 : 3'd3;
            3'd3:    return b ? 3'd4 : 3'd0;
            3'd4:    return b ? 3'd2 : 3'd0;
            default: return 3'd0;
        endcase
    endfunction

    assign det_match = (dst == 3'd4) && det_bit;

    always @(posedge clk) begin
        if (det_clr)     dst <= 3'd0;
        else if (det_en) dst <= dnext(dst, det_bit);
    end

    // Expected control tuple: {s_ready, det_en, det_clr, frame_done, busy}
    localparam logic [4:0] C_IDLE = 5'b10000;
    localparam logic [4:0] C_ACLR = 5'b10100;
    localparam logic [4:0] C_SHFT = 5'b01001;
    localparam logic [4:0] C_DONE = 5'b00011;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic [7:0] thr;
        logic [4:0] ctl;
        logic       e_thr;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    logic exp_bits[$];

    task automatic add(input logic r, input logic v, input logic [7:0] d, input logic l,
                       input logic [7:0] t, input logic [4:0] ctl, input logic [7:0] cnt,
                       input logic th);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.last = l; x.thr = t;
        x.ctl = ctl; x.e_cnt = cnt; x.e_thr = th;
        vecs.push_back(x);
    endtask

    function automatic logic [7:0] rnd();
        return 8'($urandom);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [2:0] ec;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; threshold = '0;
        v2 = 1'b0; d2 = '0; l2 = 1'b0;

        // Reset state
        add(0, 0, rnd(), 0, 0, C_IDLE, 0, 0);
        // Single word 11011000, threshold 0: match seen from T+6
        add(0, 1, 8'hD8, 1, 0, C_ACLR, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, rnd(), 0, rnd(), C_SHFT, (k >= 6) ? 8'd1 : 8'd0, 0);
        add(0, 0, rnd(), 0, rnd(), C_DONE, 1, 0);
        // Two-word frame 1B,1B with threshold 2; threshold input randomised elsewhere
        add(0, 1, 8'h1B, 0, 2, C_ACLR, 1, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, rnd(), 0, rnd(), C_SHFT, 0, 0);
        add(0, 1, 8'h1B, 1, rnd(), C_IDLE, 1, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, rnd(), 0, rnd(), C_SHFT, 1, 0);
        add(0, 0, rnd(), 0, rnd(), C_DONE, 2, 1);
        // s_valid held high with changing data through SHIFT and DONE
        add(0, 1, 8'h00, 1, 0, C_ACLR, 2, 1);
        for (int k = 1; k <= 8; k++) add(0, 1, rnd(), rnd() > 8'd127, rnd(), C_SHFT, 0, 0);
        add(0, 1, rnd(), 1, rnd(), C_DONE, 0, 0);
        add(0, 1, 8'h1B, 1, 0, C_ACLR, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, rnd(), 0, rnd(), C_SHFT, 0, 0);
        add(0, 0, rnd(), 0, rnd(), C_DONE, 1, 0);
        // Reset in the middle of a frame's second word
        add(0, 1, 8'h1B, 0, 1, C_ACLR, 1, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, rnd(), 0, rnd(), C_SHFT, 0, 0);
        add(0, 1, 8'hFF, 1, rnd(), C_IDLE, 1, 1);
        add(0, 0, rnd(), 0, rnd(), C_SHFT, 1, 1);
        add(0, 0, rnd(), 0, rnd(), C_SHFT, 1, 1);
        add(1, 0, rnd(), 0, rnd(), C_SHFT, 1, 1);
        add(0, 1, 8'h1B, 1, 0, C_ACLR, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, rnd(), 0, rnd(), C_SHFT, 0, 0);
        add(0, 0, rnd(), 0, rnd(), C_DONE, 1, 0);
        add(0, 0, rnd(), 0, rnd(), C_IDLE, 1, 0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; s_valid = vecs[i].valid; s_data = vecs[i].data;
            s_last = vecs[i].last; threshold = vecs[i].thr;
            @(negedge clk);
            check($sformatf("vec%0d ctl/thr/cnt", i),
                  {s_ready, det_en, det_clr, frame_done, busy, thr_hit, match_cnt},
                  {vecs[i].ctl, vecs[i].e_thr, vecs[i].e_cnt});
            if (vecs[i].ctl[3]) begin
                if (exp_bits.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL vec%0d det_bit: got %b expected none queued", i, det_bit);
                end else begin
                    check($sformatf("vec%0d det_bit", i), det_bit, exp_bits.pop_front());
                end
            end else begin
                check($sformatf("vec%0d det_bit idle", i), det_bit, 1'b0);
            end
            if (vecs[i].valid && vecs[i].ctl[4] && !vecs[i].rst)
                for (int b = 7; b >= 0; b--) exp_bits.push_back(vecs[i].data[b]);
            if (vecs[i].rst) exp_bits.delete();
            @(posedge clk);
            #1;
        end
        rst = 1'b0; s_valid = 1'b0;

        // Saturation: two words, every bit matches, 3-bit counter must hold at 7
        ec = 3'd0;
        for (int w = 0; w < 2; w++) begin
            v2 = 1'b1; d2 = rnd(); l2 = (w == 1);
            @(negedge clk);
            check($sformatf("sat accept%0d", w), {r2, c2, cnt2}, {1'b1, (w == 0), ec});
            @(posedge clk);
            #1 v2 = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                check($sformatf("sat w%0d bit%0d", w, k), {e2, th2, cnt2}, {1'b1, (ec == 3'd7), ec});
                @(posedge clk);
                #1;
                if (ec != 3'd7) ec = ec + 3'd1;
            end
        end
        @(negedge clk);
        check("sat done", {fd2, th2, cnt2}, {1'b1, 1'b1, 3'd7});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sat hold", {r2, bz2, cnt2}, {1'b1, 1'b0, 3'd7});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
